// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage Mini-MIPS pipeline: load-use, branch squash,
// multi-cycle multiply occupancy and data-memory wait states, plus a stall-cycle counter.
module pipeline_hazard_controller #(
  parameter int MULT_LATENCY = 4,
  parameter int REG_ADDR_W   = 5,
  parameter int STALL_CNT_W  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  ID_rs,
  input  logic [REG_ADDR_W-1:0]  ID_rt,
  input  logic                   ID_uses_rt,
  input  logic                   EX_mem_read,
  input  logic [REG_ADDR_W-1:0]  EX_rt,
  input  logic                   EX_branch_taken,
  input  logic                   EX_mult_start,
  input  logic                   MEM_access,
  input  logic                   dmem_ready,
  output logic                   pc_write,
  output logic                   IF_ID_write,
  output logic                   IF_ID_flush,
  output logic                   ID_EX_bubble,
  output logic                   pipe_freeze,
  output logic [1:0]             busy_state,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MULT_WAIT = 2'd1,
    DMEM_WAIT = 2'd2
  } state_e;

  localparam int CNT_W = (MULT_LATENCY > 2) ? $clog2(MULT_LATENCY) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LATENCY - 2);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       mult_cnt_q, mult_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic dmem_stall;
  logic load_use;

  assign dmem_stall = MEM_access && !dmem_ready;
  assign load_use   = EX_mem_read && (EX_rt != '0) &&
                      ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    mult_cnt_d   = mult_cnt_q;
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    pipe_freeze  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (dmem_stall) begin
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          pipe_freeze = 1'b1;
          state_d     = DMEM_WAIT;
        end else if (EX_branch_taken) begin
          IF_ID_write  = 1'b0;
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = 1'b1;
        end else if (EX_mult_start) begin
          pc_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
          mult_cnt_d   = MULT_LOAD;
          // A two-cycle multiply is fully covered by this RUN cycle alone.
          if (MULT_LOAD != '0) state_d = MULT_WAIT;
        end else if (load_use) begin
          pc_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
        end
      end

      MULT_WAIT: begin
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        if (dmem_stall) begin
          pipe_freeze = 1'b1;
        end else begin
          ID_EX_bubble = 1'b1;
          // The counter holds the MULT_WAIT cycles still owed, this one included.
          if (mult_cnt_q <= CNT_W'(1)) begin
            mult_cnt_d = '0;
            state_d    = RUN;
          end else begin
            mult_cnt_d = mult_cnt_q - CNT_W'(1);
          end
        end
      end

      DMEM_WAIT: begin
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        pipe_freeze = 1'b1;
        if (dmem_ready) state_d = RUN;
      end

      default: state_d = RUN;
    endcase

    if (reset) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
      pipe_freeze  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      mult_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mult_cnt_q <= mult_cnt_d;
      if (!pc_write && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign busy_state   = reset ? 2'd0 : state_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a cycles-owed behavioural model.
module tb_pipeline_hazard_controller;

  localparam int ML = 4;
  localparam int RW = 5;
  localparam int SW = 8;
  localparam longint STALL_MAX = (64'd1 << SW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [RW-1:0] ID_rs, ID_rt, EX_rt;
  logic          ID_uses_rt, EX_mem_read, EX_branch_taken, EX_mult_start;
  logic          MEM_access, dmem_ready;
  logic          pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze;
  logic [1:0]    busy_state;
  logic [SW-1:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_controller #(
    .MULT_LATENCY(ML), .REG_ADDR_W(RW), .STALL_CNT_W(SW)
  ) dut (
    .clock(clock), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .EX_mem_read(EX_mem_read), .EX_rt(EX_rt),
    .EX_branch_taken(EX_branch_taken), .EX_mult_start(EX_mult_start),
    .MEM_access(MEM_access), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .pipe_freeze(pipe_freeze),
    .busy_state(busy_state), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                       input logic urt, input logic mr, input logic [RW-1:0] ert,
                       input logic br, input logic ms, input logic ma, input logic rdy);
    @(posedge clock);
    #1;
    reset = rst; ID_rs = rs; ID_rt = rt; ID_uses_rt = urt; EX_mem_read = mr;
    EX_rt = ert; EX_branch_taken = br; EX_mult_start = ms; MEM_access = ma; dmem_ready = rdy;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Behavioural model: tracks only "waiting for dmem" and "MULT_WAIT cycles still owed".
  bit     m_known = 0;
  bit     m_dmem  = 0;
  int     m_owed  = 0;
  longint m_stall = 0;

  always @(negedge clock) begin : model
    bit       dstall, lu;
    bit [6:0] e, a;
    bit       e_pc, e_w, e_f, e_b, e_fr;
    bit [1:0] e_busy;
    dstall = MEM_access && !dmem_ready;
    lu = EX_mem_read && (EX_rt != 0) &&
         ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
    e_pc = 1; e_w = 1; e_f = 0; e_b = 0; e_fr = 0;
    e_busy = m_dmem ? 2'd2 : (m_owed > 0 ? 2'd1 : 2'd0);
    if (reset) begin
      e_pc = 0; e_w = 0; e_f = 1; e_b = 1; e_busy = 0;
    end else if (m_dmem || dstall) begin
      e_pc = 0; e_w = 0; e_fr = 1;
    end else if (m_owed > 0) begin
      e_pc = 0; e_w = 0; e_b = 1;
    end else if (EX_branch_taken) begin
      e_w = 0; e_f = 1; e_b = 1;
    end else if (EX_mult_start || lu) begin
      e_pc = 0; e_w = 0; e_b = 1;
    end
    e = {e_pc, e_w, e_f, e_b, e_fr, e_busy};
    a = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze, busy_state};
    check("model_outputs", longint'(a), longint'(e));
    if (m_known) check("model_stall_cycles", longint'(stall_cycles), m_stall);

    if (reset) begin
      m_known = 1; m_dmem = 0; m_owed = 0; m_stall = 0;
    end else begin
      if (!e_pc && m_stall < STALL_MAX) m_stall++;
      if (m_dmem) begin
        if (dmem_ready) m_dmem = 0;
      end else if (m_owed > 0) begin
        if (!dstall) m_owed--;
      end else if (dstall) begin
        m_dmem = 1;
      end else if (!EX_branch_taken && EX_mult_start) begin
        m_owed = ML - 2;
      end
    end
  end

  initial begin : stim
    int run_len;
    reset = 1; ID_rs = 0; ID_rt = 0; ID_uses_rt = 0; EX_mem_read = 0; EX_rt = 0;
    EX_branch_taken = 0; EX_mult_start = 0; MEM_access = 0; dmem_ready = 1;

    // Reset values.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_pc_write", pc_write, 0);
    check("rst_if_id_write", IF_ID_write, 0);
    check("rst_flush", IF_ID_flush, 1);
    check("rst_bubble", ID_EX_bubble, 1);
    check("rst_freeze", pipe_freeze, 0);
    check("rst_busy", busy_state, 0);
    idle();
    check("post_rst_stall_cycles", stall_cycles, 0);
    check("post_rst_pc_write", pc_write, 1);

    // Load-use on rs.
    drive(0, 5, 0, 0, 1, 5, 0, 0, 0, 1);
    check("lu_pc_write", pc_write, 0);
    check("lu_if_id_write", IF_ID_write, 0);
    check("lu_bubble", ID_EX_bubble, 1);
    idle();
    check("lu_release_pc_write", pc_write, 1);
    check("lu_stall_cycles", stall_cycles, 1);

    // Register 0 never stalls.
    drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    check("r0_pc_write", pc_write, 1);
    check("r0_bubble", ID_EX_bubble, 0);
    // rt only matters when it is a source.
    drive(0, 3, 7, 1, 1, 7, 0, 0, 0, 1);
    check("lu_rt_pc_write", pc_write, 0);
    drive(0, 3, 7, 0, 1, 7, 0, 0, 0, 1);
    check("lu_rt_unused_pc_write", pc_write, 1);

    // Taken branch beats load-use.
    drive(0, 5, 0, 0, 1, 5, 1, 0, 0, 1);
    check("br_pc_write", pc_write, 1);
    check("br_flush", IF_ID_flush, 1);
    check("br_bubble", ID_EX_bubble, 1);
    check("br_if_id_write", IF_ID_write, 0);
    idle();
    check("br_stall_cycles", stall_cycles, 2);

    // Multiply: 3 held cycles, busy 0,1,1 then 0.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("mul0_pc_write", pc_write, 0);
    check("mul0_busy", busy_state, 0);
    idle();
    check("mul1_pc_write", pc_write, 0);
    check("mul1_busy", busy_state, 1);
    idle();
    check("mul2_pc_write", pc_write, 0);
    check("mul2_busy", busy_state, 1);
    idle();
    check("mul3_pc_write", pc_write, 1);
    check("mul3_busy", busy_state, 0);
    check("mul_stall_cycles", stall_cycles, 5);

    // Multiply with a 3-cycle dmem wait inside MULT_WAIT: 6 held cycles total.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    run_len = pc_write ? 0 : 1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("mulmem_freeze", pipe_freeze, 1);
      check("mulmem_busy", busy_state, 1);
      if (!pc_write) run_len++;
    end
    for (int i = 0; i < 20; i++) begin
      idle();
      if (pc_write) break;
      run_len++;
    end
    check("mulmem_run_len", run_len, 6);

    // Reset in the middle of MULT_WAIT.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle();
    check("midrst_pre_busy", busy_state, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("midrst_pc_write", pc_write, 0);
    check("midrst_flush", IF_ID_flush, 1);
    check("midrst_busy", busy_state, 0);
    idle();
    check("midrst_after_busy", busy_state, 0);
    check("midrst_after_stall", stall_cycles, 0);
    check("midrst_after_pc_write", pc_write, 1);
    check("midrst_after_if_id_write", IF_ID_write, 1);

    // Random traffic: a long reset-free stretch (saturates the counter), then with resets.
    for (int i = 0; i < 2300; i++) begin
      drive((i >= 800) && ($urandom_range(0, 99) < 2),
            RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 35,
            RW'($urandom_range(0, 3)), $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 60);
    end

    idle();
    repeat (2) @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
